// File: rtl/mips_pkg.sv
// Shared fetch-stage types and constants for the MIPS pipeline.
package mips_pkg;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        HOLD,
        HALT
    } fetch_state_t;

    localparam logic [31:0] NOP_INSTR    = 32'h0000_0000;
    localparam logic [31:0] RESET_VECTOR = 32'hBFC0_0000;

endpackage

// File: rtl/fetch_ctrl_if.sv
// Instruction-memory read bus between the fetch controller and instruction memory.
interface fetch_ctrl_if;

    logic [31:0] imem_address;
    logic        imem_read;
    logic        imem_waitrequest;
    logic [31:0] imem_readdata;

    modport master (
        output imem_address,
        output imem_read,
        input  imem_waitrequest,
        input  imem_readdata
    );

    modport slave (
        input  imem_address,
        input  imem_read,
        output imem_waitrequest,
        output imem_readdata
    );

endinterface

// File: rtl/fetch_timeout_ctr.sv
// Consecutive-waitrequest counter; expired fires on the TIMEOUT-th wait cycle.
module fetch_timeout_ctr #(
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic inc,
    output logic expired
);

    localparam int unsigned CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] cnt;

    assign expired = inc && (cnt == CW'(TIMEOUT - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (inc && !expired) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: gates PC advance and IF/ID loading around memory waits and stalls.
// Define FETCH_SKID_EN to buffer a response that arrives during a decode stall (HOLD state).
module fetch_ctrl
    import mips_pkg::*;
#(
    parameter logic [31:0] HALT_ADDR = 32'h0000_0000,
    parameter int unsigned TIMEOUT   = 1024
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [31:0]        pc,
    input  logic               stall_id,
    fetch_ctrl_if.master       imem,
    output logic               pc_write,
    output logic               if_id_write,
    output logic               if_id_valid,
    output logic [31:0]        if_id_instr,
    output logic               halted,
    output logic               fetch_error
);

    fetch_state_t state;
    logic         at_halt;
    logic         resp;
    logic         wait_inc;
    logic         wait_clr;
    logic         expired;

`ifdef FETCH_SKID_EN
    logic [31:0]  skid_buf;
    logic         skid_vld;
`endif

    assign at_halt  = (pc == HALT_ADDR);
    assign wait_inc = (state == REQ) && !at_halt && imem.imem_waitrequest;
    assign resp     = (state == REQ) && !at_halt && !imem.imem_waitrequest;
    // Anything other than a counted wait is either a response or leaving REQ.
    assign wait_clr = !wait_inc;

    fetch_timeout_ctr #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk     (clk),
        .reset   (reset),
        .clear   (wait_clr),
        .inc     (wait_inc),
        .expired (expired)
    );

    always_comb begin
        imem.imem_read    = 1'b0;
        imem.imem_address = '0;
        pc_write          = 1'b0;
        if_id_write       = 1'b0;
        if_id_valid       = 1'b0;
        if_id_instr       = NOP_INSTR;
        unique case (state)
            REQ: begin
                if (at_halt) begin
                    if_id_write = !stall_id;
                end else begin
                    imem.imem_read    = 1'b1;
                    imem.imem_address = pc;
                    if (imem.imem_waitrequest) begin
                        if_id_write = !stall_id;
                    end else if (!stall_id) begin
                        pc_write    = 1'b1;
                        if_id_write = 1'b1;
                        if_id_valid = 1'b1;
                        if_id_instr = imem.imem_readdata;
                    end
                end
            end
            HOLD: begin
`ifdef FETCH_SKID_EN
                if (!stall_id && skid_vld) begin
                    pc_write    = 1'b1;
                    if_id_write = 1'b1;
                    if_id_valid = 1'b1;
                    if_id_instr = skid_buf;
                end
`endif
            end
            HALT: begin
                if_id_write = !stall_id;
            end
            default: begin
            end
        endcase
    end

    assign halted = (state == HALT);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            fetch_error <= 1'b0;
`ifdef FETCH_SKID_EN
            skid_buf    <= '0;
            skid_vld    <= 1'b0;
`endif
        end else begin
            unique case (state)
                IDLE: state <= REQ;
                REQ: begin
                    if (at_halt) begin
                        state <= HALT;
                    end else if (expired) begin
                        fetch_error <= 1'b1;
                        state       <= HALT;
                    end
`ifdef FETCH_SKID_EN
                    else if (resp && stall_id) begin
                        skid_buf <= imem.imem_readdata;
                        skid_vld <= 1'b1;
                        state    <= HOLD;
                    end
`endif
                end
                HOLD: begin
`ifdef FETCH_SKID_EN
                    if (!stall_id) begin
                        skid_vld <= 1'b0;
                        state    <= REQ;
                    end
`else
                    state <= REQ;
`endif
                end
                HALT: state <= HALT;
                default: state <= IDLE;
            endcase
        end
    end

    // Without the skid buffer a stalled response is simply dropped and re-requested.
    logic unused_resp;
    assign unused_resp = resp;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Scoreboard bench for fetch_ctrl; also builds with FETCH_SKID_EN defined.
module tb_fetch_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc;
    logic        stall_id;
    logic        pc_write;
    logic        if_id_write;
    logic        if_id_valid;
    logic [31:0] if_id_instr;
    logic        halted;
    logic        fetch_error;

    fetch_ctrl_if imem_bus ();

    fetch_ctrl #(
        .HALT_ADDR (32'h0000_0000),
        .TIMEOUT   (4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .pc          (pc),
        .stall_id    (stall_id),
        .imem        (imem_bus.master),
        .pc_write    (pc_write),
        .if_id_write (if_id_write),
        .if_id_valid (if_id_valid),
        .if_id_instr (if_id_instr),
        .halted      (halted),
        .fetch_error (fetch_error)
    );

    always #5 clk = ~clk;

    int          errors = 0;
    int          checks = 0;
    logic [31:0] sb[$];
    logic [31:0] exp_instr;
    bit          const_data = 1'b0;

    logic        o_read, o_pw, o_idw, o_idv, o_halt, o_err;
    logic [31:0] o_addr, o_instr, o_pc;

    function automatic logic [31:0] mem(input logic [31:0] a);
        if (const_data) return 32'h2402_0005;
        return {16'h2403, a[15:0]};
    endfunction

    task automatic drive(input logic w, input logic s);
        imem_bus.imem_waitrequest = w;
        stall_id                  = s;
        imem_bus.imem_readdata    = w ? 32'hDEAD_BEEF : mem(pc);
    endtask

    // Sample on the falling edge, then advance past the rising edge and move the PC model.
    task automatic tick();
        @(negedge clk);
        o_read  = imem_bus.imem_read;
        o_addr  = imem_bus.imem_address;
        o_pw    = pc_write;
        o_idw   = if_id_write;
        o_idv   = if_id_valid;
        o_instr = if_id_instr;
        o_halt  = halted;
        o_err   = fetch_error;
        o_pc    = pc;
        @(posedge clk);
        #1;
        if (o_pw) pc = pc + 32'd4;
    endtask

    task automatic do_reset(input logic [31:0] start_pc);
        pc    = start_pc;
        drive(1'b0, 1'b0);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        pc    = 32'h0000_0100;
        drive(1'b0, 1'b0);
        #2;
        checks++;
        if ({imem_bus.imem_read, pc_write, if_id_write, if_id_valid, halted, fetch_error} !== 6'b0) begin
            errors++;
            $display("FAIL reset_outputs: got %b want 000000",
                     {imem_bus.imem_read, pc_write, if_id_write, if_id_valid, halted, fetch_error});
        end
        @(posedge clk);
        #1 reset = 1'b0;
        drive(1'b0, 1'b0);
        tick();
        checks++;
        if ({o_read, o_pw, o_idv, o_halt} !== 4'b0) begin
            errors++;
            $display("FAIL idle_cycle: read/pw/valid/halted=%b want 0000", {o_read, o_pw, o_idv, o_halt});
        end
    endtask

    task automatic test_basic();
        const_data = 1'b1;
        for (int i = 0; i < 6; i++) sb.push_back(32'h2402_0005);
        for (int i = 0; i < 6; i++) begin
            drive(1'b0, 1'b0);
            tick();
            checks++;
            if ({o_read, o_pw, o_idw, o_idv} !== 4'b1111 || o_addr !== o_pc) begin
                errors++;
                $display("FAIL basic_ctl[%0d]: read/pw/idw/idv=%b addr=%h want 1111 addr=%h",
                         i, {o_read, o_pw, o_idw, o_idv}, o_addr, o_pc);
            end
            if (o_idw && o_idv) begin
                exp_instr = sb.pop_front();
                checks++;
                if (o_instr !== exp_instr) begin
                    errors++;
                    $display("FAIL basic_instr[%0d]: got %h want %h", i, o_instr, exp_instr);
                end
            end
        end
        const_data = 1'b0;
    endtask

    task automatic test_wait();
        sb.push_back(mem(pc));
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0);
            tick();
            checks++;
            if ({o_read, o_pw, o_idw, o_idv} !== 4'b1010 || o_instr !== 32'h0) begin
                errors++;
                $display("FAIL wait_bubble[%0d]: read/pw/idw/idv=%b instr=%h want 1010 instr=0",
                         i, {o_read, o_pw, o_idw, o_idv}, o_instr);
            end
        end
        drive(1'b0, 1'b0);
        tick();
        checks++;
        if ({o_pw, o_idw, o_idv} !== 3'b111) begin
            errors++;
            $display("FAIL wait_release: pw/idw/idv=%b want 111", {o_pw, o_idw, o_idv});
        end
        if (o_idw && o_idv) begin
            exp_instr = sb.pop_front();
            checks++;
            if (o_instr !== exp_instr) begin
                errors++;
                $display("FAIL wait_instr: got %h want %h", o_instr, exp_instr);
            end
        end
    endtask

    task automatic test_stall();
        logic [31:0] base;
        int          reads;
        int          loads;
        base  = pc;
        reads = 0;
        loads = 0;
        sb.push_back(mem(base));
        sb.push_back(mem(base + 32'd4));
        for (int c = 0; c < 4; c++) begin
            drive(1'b0, c < 2);
`ifdef FETCH_SKID_EN
            if (c == 2) imem_bus.imem_readdata = 32'hBAD0_BAD0;
`endif
            tick();
            if (c < 3) reads += int'(o_read);
            if (c < 2) begin
                checks++;
                if ({o_pw, o_idw} !== 2'b00) begin
                    errors++;
                    $display("FAIL stall_gate[%0d]: pw/idw=%b want 00", c, {o_pw, o_idw});
                end
            end
`ifndef FETCH_SKID_EN
            if (c < 3) begin
                checks++;
                if (o_read !== 1'b1 || o_addr !== base) begin
                    errors++;
                    $display("FAIL stall_reread[%0d]: read=%b addr=%h want 1 addr=%h", c, o_read, o_addr, base);
                end
            end
`endif
            if (o_idw && o_idv) begin
                loads++;
                if (sb.size() == 0) exp_instr = 32'hXXXX_XXXX;
                else exp_instr = sb.pop_front();
                checks++;
                if (o_instr !== exp_instr) begin
                    errors++;
                    $display("FAIL stall_instr[%0d]: got %h want %h", c, o_instr, exp_instr);
                end
            end
        end
`ifdef FETCH_SKID_EN
        checks++;
        if (reads != 1) begin
            errors++;
            $display("FAIL skid_reads: got %0d want 1", reads);
        end
`else
        checks++;
        if (reads != 3) begin
            errors++;
            $display("FAIL noskid_reads: got %0d want 3", reads);
        end
`endif
        checks++;
        if (loads != 2 || sb.size() != 0 || pc !== base + 32'd8) begin
            errors++;
            $display("FAIL stall_stream: loads=%0d left=%0d pc=%h want 2 0 %h", loads, sb.size(), pc, base + 32'd8);
        end
    endtask

    task automatic test_halt();
        pc = 32'h0000_0000;
        drive(1'b0, 1'b0);
        tick();
        checks++;
        if ({o_read, o_pw, o_idv, o_halt} !== 4'b0000) begin
            errors++;
            $display("FAIL halt_entry: read/pw/idv/halted=%b want 0000", {o_read, o_pw, o_idv, o_halt});
        end
        for (int i = 0; i < 3; i++) begin
            pc = (i == 1) ? 32'h0000_0300 : 32'h0000_0000;
            drive(1'b0, i == 2);
            tick();
            checks++;
            if ({o_halt, o_read, o_pw, o_idv, o_err} !== 5'b10000 || o_instr !== 32'h0 ||
                o_idw !== (i != 2)) begin
                errors++;
                $display("FAIL halt_hold[%0d]: halted/read/pw/idv/err=%b idw=%b instr=%h want 10000 idw=%b instr=0",
                         i, {o_halt, o_read, o_pw, o_idv, o_err}, o_idw, o_instr, i != 2);
            end
        end
    endtask

    task automatic test_timeout();
        do_reset(32'h0000_0400);
        drive(1'b1, 1'b0);
        tick();
        for (int i = 1; i <= 4; i++) begin
            drive(1'b1, 1'b0);
            tick();
            checks++;
            if ({o_err, o_halt, o_read} !== 3'b001) begin
                errors++;
                $display("FAIL timeout_wait[%0d]: err/halted/read=%b want 001", i, {o_err, o_halt, o_read});
            end
        end
        drive(1'b1, 1'b0);
        tick();
        checks++;
        if ({o_err, o_halt, o_read} !== 3'b110) begin
            errors++;
            $display("FAIL timeout_halt: err/halted/read=%b want 110", {o_err, o_halt, o_read});
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({fetch_error, halted} !== 2'b00) begin
            errors++;
            $display("FAIL timeout_reset: err/halted=%b want 00", {fetch_error, halted});
        end
        @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic test_reset_mid_wait();
        do_reset(32'h0000_0500);
        drive(1'b1, 1'b0);
        tick();
        repeat (2) begin
            drive(1'b1, 1'b0);
            tick();
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({imem_bus.imem_read, pc_write, if_id_write, if_id_valid, halted, fetch_error} !== 6'b0 ||
            imem_bus.imem_address !== 32'h0 || if_id_instr !== 32'h0) begin
            errors++;
            $display("FAIL midwait_reset: ctl=%b addr=%h instr=%h want 000000 0 0",
                     {imem_bus.imem_read, pc_write, if_id_write, if_id_valid, halted, fetch_error},
                     imem_bus.imem_address, if_id_instr);
        end
        @(posedge clk);
        #1 reset = 1'b0;
        sb.push_back(mem(pc));
        drive(1'b0, 1'b0);
        tick();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0);
            tick();
        end
        drive(1'b0, 1'b0);
        tick();
        checks++;
        if ({o_err, o_halt, o_pw, o_idv} !== 4'b0011) begin
            errors++;
            $display("FAIL counter_cleared: err/halted/pw/idv=%b want 0011", {o_err, o_halt, o_pw, o_idv});
        end
        if (o_idw && o_idv) begin
            exp_instr = sb.pop_front();
            checks++;
            if (o_instr !== exp_instr) begin
                errors++;
                $display("FAIL midwait_instr: got %h want %h", o_instr, exp_instr);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_basic();
        test_wait();
        test_stall();
        test_halt();
        test_timeout();
        test_reset_mid_wait();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left want 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 Parameter HALT_ADDR, default 32'h00000000: PC value at which fetch SHALL stop.
REQ-002 Parameter TIMEOUT, default 1024: maximum consecutive waitrequest cycles before error.
REQ-003 clk  in  1  sole clock; all state SHALL update on its rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 pc  in  32  current PC register value.
REQ-006 stall_id  in  1  decode hazard stall; IF/ID SHALL hold while high.
REQ-007 imem_address  out  32  instruction memory address.
REQ-008 imem_read  out  1  instruction memory read request.
REQ-009 imem_waitrequest  in  1  memory not ready; readdata is valid in the cycle this is low with imem_read high.
REQ-010 imem_readdata  in  32  fetched instruction.
REQ-011 pc_write  out  1  PC advance enable (drives PCWrite).
REQ-012 if_id_write  out  1  IF/ID register load enable.
REQ-013 if_id_valid  out  1  0 = bubble (NOP) loaded into IF/ID.
REQ-014 if_id_instr  out  32  instruction presented to IF/ID.
REQ-015 halted  out  1  high in HALT state.
REQ-016 fetch_error  out  1  sticky timeout flag.

Function
REQ-017 FSM states: IDLE, REQ, HOLD, HALT; IDLE SHALL go to REQ unconditionally on the next edge.
REQ-018 In REQ: imem_read=1, imem_address=pc (combinational); all other states: imem_read=0, imem_address=0.
REQ-019 REQ, waitrequest=0, stall_id=0: pc_write=1, if_id_write=1, if_id_valid=1, if_id_instr=imem_readdata; stay in REQ (one instruction per cycle at zero wait).
REQ-020 REQ, waitrequest=1: pc_write=0; if_id_write=!stall_id with if_id_valid=0 (bubble); the wait counter SHALL increment.
REQ-021 Wait counter SHALL clear on every accepted response and on leaving REQ; reaching TIMEOUT SHALL set fetch_error and move to HALT.
REQ-022 REQ with pc==HALT_ADDR SHALL move to HALT without issuing a read (imem_read=0 in that cycle).
REQ-023 HALT: pc_write=0, imem_read=0, if_id_write=!stall_id, if_id_valid=0, halted=1; exit only by reset.
REQ-024 stall_id with a response in the same cycle: pc_write=0, if_id_write=0; handling per REQ-030/031.
REQ-025 if_id_instr SHALL be 32'h0 whenever if_id_valid=0.
REQ-026 Branch and jump target selection SHALL remain in the PC module; fetch_ctrl gates only the advance, and delay-slot instructions SHALL be fetched normally.

Reset
REQ-027 On reset assertion, state=IDLE, and imem_read, pc_write, if_id_write, if_id_valid, halted and fetch_error SHALL be 0 immediately (asynchronously).
REQ-028 On reset assertion, the wait counter, skid buffer and buffer-valid flag SHALL clear.
REQ-029 Reset mid-transaction SHALL abandon the outstanding read; no response SHALL be consumed afterwards.

Configuration
REQ-030 Macro FETCH_SKID_EN defined: a response arriving with stall_id=1 SHALL be captured into a 1-entry buffer and the FSM SHALL go to HOLD. In HOLD with stall_id=0, it SHALL drive if_id_write=1, if_id_valid=1, if_id_instr=buffer and pc_write=1, then return to REQ.
REQ-031 Macro FETCH_SKID_EN undefined: HOLD is unused; a response arriving with stall_id=1 SHALL be discarded and the same pc re-requested next cycle.

Structure
REQ-032 Package mips_pkg SHALL hold the fetch_state_t enum, NOP_INSTR=32'h0 and the RESET_VECTOR=32'hBFC00000 constant.
REQ-033 The wait/timeout counter SHALL be the sub-module fetch_timeout_ctr (inputs: clear, inc; output: expired).

Verification
REQ-034 Reset, waitrequest=0, stall_id=0, imem_readdata=32'h24020005 -> from cycle 2, pc_write=1, if_id_valid=1, if_id_instr=32'h24020005 every cycle.
REQ-035 waitrequest high for 3 cycles -> 3 bubbles (if_id_valid=0, pc_write=0), then one valid load with pc_write=1.
REQ-036 stall_id=1 for 2 cycles during a response -> with FETCH_SKID_EN: HOLD, then the buffered instruction loads once stall_id drops and exactly one read is issued; without it: the same address is re-read and no instruction is duplicated or lost.
REQ-037 pc=32'h0 while in REQ -> halted=1, imem_read=0 permanently, IF/ID receives bubbles.
REQ-038 TIMEOUT=4, waitrequest stuck at 1 -> fetch_error=1 after the 4th wait cycle and the FSM enters HALT. Asserting reset mid-wait -> all outputs 0 in the same cycle.
